// File: rtl/sort_pkg.sv
// Shared types and helpers for the bubble-sort stage chain and its unload collector.
package sort_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        DRAIN   = 2'b10
    } state_t;

    // Bits needed to hold values 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/sort_fifo.sv
// Show-ahead FIFO: head word visible while not empty, reads as zero when empty.
// A pop frees a slot for a push on the same edge, even when full.
module sort_fifo
    import sort_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             single
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign single  = (count == (AW+1)'(1));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sort_collect.sv
// Rebuilds MSB-first serial sorted values into words and hands them out over valid/ready.
// The serial side cannot stall: a word completing into a full FIFO is dropped and flagged.
module sort_collect
    import sort_pkg::*;
#(
    parameter int N_BITS  = 8,
    parameter int N_WORDS = 8,
    parameter int DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              bit_i,
    input  logic              bit_valid_i,
    output logic [N_BITS-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              overflow_o
);

    localparam int BW = clog2(N_BITS);
    localparam int WW = clog2(N_WORDS + 1);

    state_t            state;
    state_t            state_nxt;
    logic [BW-1:0]     bit_cnt;
    logic [WW-1:0]     word_cnt;
    logic [N_BITS-1:0] shift_reg;
    logic [N_BITS-1:0] word;
    logic              overflow;
    logic              done;
    logic              finish;
    logic              take_bit;
    logic              word_done;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_single;

    assign take_bit  = (state == COLLECT) && bit_valid_i;
    assign word_done = take_bit && (bit_cnt == BW'(N_BITS - 1));
    assign word      = {shift_reg[N_BITS-2:0], bit_i};
    assign pop       = !fifo_empty && ready_i;

    sort_fifo #(.WIDTH(N_BITS), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (word_done),
        .wr_data (word),
        .pop     (pop),
        .rd_data (data_o),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .single  (fifo_single)
    );

    always_comb begin
        state_nxt = state;
        finish    = 1'b0;
        unique case (state)
            IDLE:    if (start_i) state_nxt = COLLECT;
            COLLECT: if (word_done && word_cnt == WW'(N_WORDS - 1)) state_nxt = DRAIN;
            DRAIN: begin
                // DRAIN is always entered non-empty, so the last pop ends the run.
                if (pop && fifo_single) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= finish;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            word_cnt  <= '0;
            shift_reg <= '0;
            overflow  <= 1'b0;
        end else if (state == IDLE && start_i) begin
            bit_cnt   <= '0;
            word_cnt  <= '0;
            shift_reg <= '0;
            overflow  <= 1'b0;
        end else if (take_bit) begin
            shift_reg <= word;
            if (word_done) begin
                bit_cnt  <= '0;
                word_cnt <= word_cnt + 1'b1;
                if (fifo_full && !pop) overflow <= 1'b1;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    assign valid_o    = !fifo_empty;
    assign busy_o     = (state != IDLE);
    assign done_o     = done;
    assign overflow_o = overflow;

endmodule

// File: tb/tb_sort_collect.sv
// Three collectors (1, 4 and 6 words per run, 8-bit words, 4-deep FIFO) checked against a queue-level model.
module tb_sort_collect;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [2:0]      st = '0, bv = '0, bi = '0, rd = '0;
    logic [2:0][7:0] dat;
    logic [2:0]      vld, bsy, dn, ovf;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            sort_collect #(.N_BITS(8), .N_WORDS((g == 0) ? 1 : (g == 1) ? 4 : 6), .DEPTH(4)) dut (
                .clk         (clk),
                .rst_n       (rst_n),
                .start_i     (st[g]),
                .bit_i       (bi[g]),
                .bit_valid_i (bv[g]),
                .data_o      (dat[g]),
                .valid_o     (vld[g]),
                .ready_i     (rd[g]),
                .busy_o      (bsy[g]),
                .done_o      (dn[g]),
                .overflow_o  (ovf[g])
            );
        end
    endgenerate

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    endtask

    // Reference model: run mode (0 idle, 1 collecting, 2 draining) plus a plain array as the FIFO.
    int         mmode[3], mbits[3], mwords[3], mcnt[3];
    logic [7:0] macc[3];
    logic [7:0] mq[3][4];
    bit         movf[3], mdone[3];

    function automatic int nw(input int i);
        return (i == 0) ? 1 : (i == 1) ? 4 : 6;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mmode[i] = 0; mbits[i] = 0; mwords[i] = 0; mcnt[i] = 0;
            macc[i] = '0; movf[i] = 1'b0; mdone[i] = 1'b0;
        end
    endtask

    task automatic model_step(input int i);
        bit pop, push, was_drain;
        logic [7:0] w;
        pop = (mcnt[i] > 0) && rd[i];
        push = 1'b0;
        w = '0;
        was_drain = (mmode[i] == 2);
        mdone[i] = 1'b0;
        if (mmode[i] == 0) begin
            if (st[i]) begin
                mmode[i] = 1; mbits[i] = 0; mwords[i] = 0; macc[i] = '0; movf[i] = 1'b0;
            end
        end else if (mmode[i] == 1 && bv[i]) begin
            macc[i] = {macc[i][6:0], bi[i]};
            mbits[i]++;
            if (mbits[i] == 8) begin
                push = 1'b1; w = macc[i]; mbits[i] = 0; mwords[i]++;
                if (mwords[i] == nw(i)) mmode[i] = 2;
            end
        end
        if (pop) begin
            for (int k = 0; k < 3; k++) mq[i][k] = mq[i][k+1];
            mcnt[i]--;
        end
        if (push) begin
            if (mcnt[i] < 4) begin
                mq[i][mcnt[i]] = w;
                mcnt[i]++;
            end else movf[i] = 1'b1;
        end
        if (was_drain && pop && mcnt[i] == 0) begin
            mmode[i] = 0;
            mdone[i] = 1'b1;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else for (int i = 0; i < 3; i++) model_step(i);
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d.valid", i), 32'(vld[i]), 32'(mcnt[i] > 0));
                chk($sformatf("u%0d.data", i), 32'(dat[i]), 32'((mcnt[i] > 0) ? mq[i][0] : 8'h00));
                chk($sformatf("u%0d.busy", i), 32'(bsy[i]), 32'(mmode[i] != 0));
                chk($sformatf("u%0d.done", i), 32'(dn[i]), 32'(mdone[i]));
                chk($sformatf("u%0d.overflow", i), 32'(ovf[i]), 32'(movf[i]));
            end
        end
    end

    // All driving tasks are entered at a falling edge and return at one.
    task automatic start_run(input int i);
        st[i] = 1'b1;
        @(negedge clk);
        st[i] = 1'b0;
    endtask

    task automatic send_bits(input int i, input logic [7:0] w, input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            bv[i] = 1'b1;
            bi[i] = w[7-k];
            @(negedge clk);
            if (k != n - 1) begin
                repeat (gap) begin
                    bv[i] = 1'b0;
                    @(negedge clk);
                end
            end
        end
        bv[i] = 1'b0;
    endtask

    task automatic drain_expect(input int i, input int n, input logic [7:0] exp [6]);
        int got;
        got = 0;
        rd[i] = 1'b1;
        for (int c = 0; c < 100 && got < n; c++) begin
            if (vld[i]) begin
                chk($sformatf("u%0d.pop%0d", i, got), 32'(dat[i]), 32'(exp[got]));
                got++;
            end
            @(negedge clk);
        end
        chk($sformatf("u%0d.pop_count", i), 32'(got), 32'(n));
        chk($sformatf("u%0d.done_after_last_pop", i), 32'(dn[i]), 32'd1);
        chk($sformatf("u%0d.busy_after_last_pop", i), 32'(bsy[i]), 32'd0);
    endtask

    task automatic wait_idle(input int i);
        for (int c = 0; c < 300 && bsy[i]; c++) @(negedge clk);
        chk($sformatf("u%0d.returns_idle", i), 32'(bsy[i]), 32'd0);
    endtask

    typedef struct {
        logic [7:0] word;
        int         gap;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[5];
    logic [7:0] exp6 [6];

    initial begin
        tbl[0] = '{8'hA5, 0, 8'hA5};
        tbl[1] = '{8'hA5, 1, 8'hA5};
        tbl[2] = '{8'h3C, 0, 8'h3C};
        tbl[3] = '{8'hFF, 2, 8'hFF};
        tbl[4] = '{8'h00, 1, 8'h00};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        chk("reset.valid", 32'(vld), 32'd0);
        chk("reset.data", 32'(dat), 32'd0);
        chk("reset.busy", 32'(bsy), 32'd0);
        chk("reset.done", 32'(dn), 32'd0);
        chk("reset.overflow", 32'(ovf), 32'd0);

        // Single-word runs: word appears the cycle after its 8th valid bit, pops at once.
        rd[0] = 1'b1;
        for (int t = 0; t < 5; t++) begin
            start_run(0);
            send_bits(0, tbl[t].word, 8, tbl[t].gap);
            chk($sformatf("tbl%0d.valid", t), 32'(vld[0]), 32'd1);
            chk($sformatf("tbl%0d.data", t), 32'(dat[0]), 32'(tbl[t].exp));
            @(negedge clk);
            chk($sformatf("tbl%0d.done", t), 32'(dn[0]), 32'd1);
            chk($sformatf("tbl%0d.busy", t), 32'(bsy[0]), 32'd0);
            @(negedge clk);
            chk($sformatf("tbl%0d.done_single", t), 32'(dn[0]), 32'd0);
        end

        // Four words into a four-deep FIFO with the consumer stalled: full, no overflow.
        rd[1] = 1'b0;
        start_run(1);
        for (int w = 1; w <= 4; w++) send_bits(1, 8'(w), 8, 0);
        repeat (3) @(negedge clk);
        chk("fill4.overflow", 32'(ovf[1]), 32'd0);
        chk("fill4.head", 32'(dat[1]), 32'h01);
        chk("fill4.busy", 32'(bsy[1]), 32'd1);
        exp6 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00};
        drain_expect(1, 4, exp6);

        // Six words, consumer stalled: last two dropped, overflow sticky until the next start.
        rd[2] = 1'b0;
        start_run(2);
        for (int w = 0; w < 6; w++) send_bits(2, 8'h21 + 8'(w), 8, 0);
        chk("drop.overflow", 32'(ovf[2]), 32'd1);
        exp6 = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h00, 8'h00};
        drain_expect(2, 4, exp6);
        chk("drop.overflow_held", 32'(ovf[2]), 32'd1);
        rd[2] = 1'b0;
        start_run(2);
        chk("drop.overflow_cleared", 32'(ovf[2]), 32'd0);
        rd[2] = 1'b1;
        for (int w = 0; w < 6; w++) send_bits(2, 8'h40 + 8'(w), 8, 0);
        wait_idle(2);

        // FIFO full and the consumer takes a word on the very edge the fifth word lands.
        rd[2] = 1'b0;
        start_run(2);
        for (int w = 0; w < 4; w++) send_bits(2, 8'h10 + 8'(w), 8, 0);
        send_bits(2, 8'h14, 7, 0);
        rd[2] = 1'b1;
        send_bits(2, 8'h14 << 7, 1, 0);
        chk("race.overflow", 32'(ovf[2]), 32'd0);
        chk("race.head", 32'(dat[2]), 32'h11);
        send_bits(2, 8'h15, 8, 0);
        wait_idle(2);
        chk("race.overflow_end", 32'(ovf[2]), 32'd0);

        // Asynchronous reset in the middle of a word with two words buffered.
        rd[1] = 1'b0;
        start_run(1);
        send_bits(1, 8'h01, 8, 0);
        send_bits(1, 8'h02, 8, 0);
        send_bits(1, 8'hFF, 3, 0);
        chk("prereset.valid", 32'(vld[1]), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset.valid", 32'(vld[1]), 32'd0);
        chk("midreset.data", 32'(dat[1]), 32'd0);
        chk("midreset.busy", 32'(bsy[1]), 32'd0);
        chk("midreset.done", 32'(dn[1]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start_run(1);
        send_bits(1, 8'h3C, 8, 0);
        chk("postreset.head", 32'(dat[1]), 32'h3C);
        for (int w = 0; w < 3; w++) send_bits(1, 8'h11 * 8'(w + 1), 8, 0);
        exp6 = '{8'h3C, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00};
        drain_expect(1, 4, exp6);

        // Random serial streams, gaps, stray bits outside collection and consumer stalls.
        for (int i = 0; i < 3; i++) begin
            for (int r = 0; r < 4; r++) begin
                int cyc;
                bv[i] = 1'b0;
                rd[i] = 1'($urandom_range(0, 1));
                start_run(i);
                cyc = 0;
                while (mmode[i] != 0 && cyc < 2000) begin
                    bv[i] = ($urandom_range(0, 3) != 0);
                    bi[i] = 1'($urandom);
                    rd[i] = (r == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    cyc++;
                end
                chk($sformatf("rand.u%0d.r%0d.bounded", i, r), 32'(cyc < 2000), 32'd1);
                bv[i] = 1'(1'($urandom));
                @(negedge clk);
                bv[i] = 1'b0;
                rd[i] = 1'b0;
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
